// File: rtl/conv_bus_pkg.sv
// conv_bus_pkg: shared widths, ids and types for the conv write-bus arbiter
package conv_bus_pkg;
  localparam int ADDR_W = 28;
  localparam int ID_W = 4;
  localparam int LEN_W = 4;
  localparam logic [ID_W-1:0] CONV_WR_ID = 4'h2;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} arb_state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic ap;
    logic [ID_W-1:0] id;
    logic [LEN_W-1:0] len;
  } aw_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from ptr upward with wrap
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW:0] j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = (IW+1)'(ptr_i) + (IW+1)'(k);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      if (!(|gnt_o) && req_i[j[IW-1:0]]) begin
        gnt_o[j[IW-1:0]] = 1'b1;
        idx_o = j[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/conv_wr_bus_arbiter.sv
// conv_wr_bus_arbiter: round-robin share of one AW+W bus port between NREQ conv write bridges
module conv_wr_bus_arbiter
  import conv_bus_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
  parameter int WR_LAT = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ*ADDR_W-1:0]  req_awaddr,
  input  logic [NREQ-1:0]         req_awuser_ap,
  input  logic [NREQ*ID_W-1:0]    req_awuser_id,
  input  logic [NREQ*LEN_W-1:0]   req_awlen,
  input  logic [NREQ-1:0]         req_awvalid,
  output logic [NREQ-1:0]         req_awready,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  input  logic [NREQ*WIDTH/8-1:0] req_wstrb,
  output logic [NREQ-1:0]         req_wready,
  output logic [NREQ-1:0]         req_wuser_last,
  output logic [ADDR_W-1:0]       awaddr,
  output logic                    awuser_ap,
  output logic [ID_W-1:0]         awuser_id,
  output logic [LEN_W-1:0]        awlen,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [WIDTH-1:0]        wdata,
  output logic [WIDTH/8-1:0]      wstrb,
  input  logic                    wready,
  input  logic [ID_W-1:0]         wuser_id,
  input  logic                    wuser_last,
  output logic [NREQ-1:0]         grant,
  output logic                    err_len,
  output logic                    err_timeout
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(WR_LAT + 2);
  localparam int SW = WIDTH / 8;
  arb_state_e state_q;
  logic [NREQ-1:0] grant_q, req_awready_q, arb_gnt;
  logic [IW-1:0] gidx_q, ptr_q, arb_idx, nxt_ptr;
  aw_req_t txn_q, arb_req;
  logic awvalid_q, err_len_q, err_timeout_q, act, match, wdog_hit;
  logic [LEN_W-1:0] beat_q;
  logic [DW-1:0] drain_q;
  logic [TW-1:0] wdog_q;
  rr_arbiter #(.N(NREQ)) u_rr (.req_i(req_awvalid), .ptr_i(ptr_q), .gnt_o(arb_gnt), .idx_o(arb_idx));
  assign arb_req = {req_awaddr[arb_idx*ADDR_W +: ADDR_W], req_awuser_ap[arb_idx],
                    req_awuser_id[arb_idx*ID_W +: ID_W], req_awlen[arb_idx*LEN_W +: LEN_W]};
  assign nxt_ptr = gidx_q == IW'(NREQ - 1) ? '0 : gidx_q + 1'b1;
  assign wdog_hit = wdog_q == TW'(TIMEOUT - 1);
  assign act = state_q == DATA || state_q == DRAIN;
  assign match = act && wready && wuser_id == txn_q.id;
  // txn_q keeps id/len for the data phase, so the bus AW fields are gated by awvalid
  assign awaddr = awvalid_q ? txn_q.addr : '0;
  assign awuser_ap = awvalid_q & txn_q.ap;
  assign awuser_id = awvalid_q ? txn_q.id : '0;
  assign awlen = awvalid_q ? txn_q.len : '0;
  assign awvalid = awvalid_q;
  assign wdata = act ? req_wdata[gidx_q*WIDTH +: WIDTH] : '0;
  assign wstrb = act ? req_wstrb[gidx_q*SW +: SW] : '0;
  assign req_wready = match ? grant_q : '0;
  assign req_wuser_last = match && wuser_last ? grant_q : '0;
  assign req_awready = req_awready_q;
  assign grant = grant_q;
  assign err_len = err_len_q;
  assign err_timeout = err_timeout_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q <= '0;
      ptr_q <= '0;
      txn_q <= '0;
      awvalid_q <= 1'b0;
      req_awready_q <= '0;
      beat_q <= '0;
      drain_q <= '0;
      wdog_q <= '0;
      err_len_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      req_awready_q <= '0;
      err_len_q <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (|req_awvalid) begin
          state_q <= ADDR;
          grant_q <= arb_gnt;
          gidx_q <= arb_idx;
          txn_q <= arb_req;
          awvalid_q <= 1'b1;
          wdog_q <= '0;
        end
        ADDR: if (awready) begin
          state_q <= DATA;
          awvalid_q <= 1'b0;
          req_awready_q <= grant_q;
          ptr_q <= nxt_ptr;
          beat_q <= '0;
          wdog_q <= '0;
        end else if (wdog_hit) begin
          state_q <= IDLE;
          awvalid_q <= 1'b0;
          grant_q <= '0;
          ptr_q <= nxt_ptr;
          err_timeout_q <= 1'b1;
          wdog_q <= '0;
        end else wdog_q <= wdog_q + 1'b1;
        DATA: if (match) begin
          beat_q <= beat_q == '1 ? beat_q : beat_q + 1'b1;
          wdog_q <= '0;
          if (wuser_last) begin
            err_len_q <= ({1'b0, beat_q} + 5'd1) != {1'b0, txn_q.len};
            drain_q <= DW'(WR_LAT);
            state_q <= DRAIN;
          end else err_len_q <= beat_q == txn_q.len;
        end else if (wdog_hit) begin
          state_q <= IDLE;
          grant_q <= '0;
          err_timeout_q <= 1'b1;
          wdog_q <= '0;
        end else wdog_q <= wdog_q + 1'b1;
        default: if (drain_q == '0) begin
          state_q <= IDLE;
          grant_q <= '0;
          wdog_q <= '0;
        end else drain_q <= drain_q - 1'b1;
      endcase
    end
  end
endmodule
